// File: rtl/pwm_timer_ctrl_pkg.sv
// pwm_timer_ctrl shared definitions.
// Sequencer state encodings, default widths, functions bit map.
package pwm_timer_ctrl_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int PRESC_W_DEF  = 8;
  localparam int FN_ALIGN     = 0;
  localparam int FN_UNALIGNED = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_RUN_PEND = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_timer_ctrl_prescaler.sv
// pwm_prescaler: clock divider for the pwm timebase.
// Ticks every limit+1 enabled clocks; clear restarts the count.
module pwm_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         tick
);

  logic [W-1:0] cnt;

  // >= keeps the divider sane if limit shrinks below a held count
  assign tick = enable && (cnt >= limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/pwm_timer_ctrl.sv
// pwm_timer_ctrl: timebase and double-buffered config for pwm_gen.
// Shadow config is applied only at period boundaries or while idle.
module pwm_timer_ctrl
  import pwm_timer_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               count_reset,
  input  logic               cfg_update,
  input  logic [PRESC_W-1:0] cfg_prescale,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [7:0]         cfg_functions,
  input  logic [CNT_W-1:0]   cfg_compare1,
  input  logic [CNT_W-1:0]   cfg_compare2,
  output logic               pwm_en,
  output logic [CNT_W-1:0]   count_val,
  output logic [CNT_W-1:0]   period,
  output logic [7:0]         functions,
  output logic [CNT_W-1:0]   compare1,
  output logic [CNT_W-1:0]   compare2,
  output logic               period_wrap,
  output logic               update_pending,
  output logic               update_done
);

  state_t             state;
  logic               running;
  logic               tick;
  logic               wrap;
  logic               apply;
  logic               pend_nxt;
  logic [PRESC_W-1:0] sh_presc;
  logic [PRESC_W-1:0] act_presc;
  logic [CNT_W-1:0]   sh_period;
  logic [CNT_W-1:0]   sh_cmp1;
  logic [CNT_W-1:0]   sh_cmp2;
  logic [7:0]         sh_fn;

  assign running = (state != ST_IDLE);

  pwm_prescaler #(.W(PRESC_W)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (count_reset),
    .enable (running),
    .limit  (act_presc),
    .tick   (tick)
  );

  assign wrap = tick && !count_reset && (count_val >= period);

  // a fresh capture always waits for the following boundary
  assign apply = update_pending && !cfg_update
              && (!running || wrap || count_reset);

  assign pend_nxt = cfg_update || (update_pending && !apply);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pwm_en         <= 1'b0;
      count_val      <= '0;
      period         <= '0;
      functions      <= '0;
      compare1       <= '0;
      compare2       <= '0;
      act_presc      <= '0;
      sh_presc       <= '0;
      sh_period      <= '0;
      sh_fn          <= '0;
      sh_cmp1        <= '0;
      sh_cmp2        <= '0;
      period_wrap    <= 1'b0;
      update_pending <= 1'b0;
      update_done    <= 1'b0;
    end else begin
      pwm_en         <= en;
      period_wrap    <= wrap;
      update_done    <= apply;
      update_pending <= pend_nxt;

      unique case (1'b1)
        !en:             state <= ST_IDLE;
        en && pend_nxt:  state <= ST_RUN_PEND;
        en && !pend_nxt: state <= ST_RUN;
        default:         state <= ST_IDLE;
      endcase

      if (cfg_update) begin
        sh_presc  <= cfg_prescale;
        sh_period <= cfg_period;
        sh_fn     <= cfg_functions;
        sh_cmp1   <= cfg_compare1;
        sh_cmp2   <= cfg_compare2;
      end

      if (apply) begin
        act_presc <= sh_presc;
        period    <= sh_period;
        functions <= sh_fn;
        compare1  <= sh_cmp1;
        compare2  <= sh_cmp2;
      end

      if (count_reset) begin
        count_val <= '0;
      end else if (tick) begin
        count_val <= wrap ? '0 : count_val + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// tb_pwm_timer_ctrl: scenario tasks plus randomized run
// checked against a cycle reference model.
module tb_pwm_timer_ctrl;

  localparam int CW = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          count_reset = 1'b0;
  logic          cfg_update = 1'b0;
  logic [PW-1:0] cfg_prescale = '0;
  logic [CW-1:0] cfg_period = '0;
  logic [7:0]    cfg_functions = '0;
  logic [CW-1:0] cfg_compare1 = '0;
  logic [CW-1:0] cfg_compare2 = '0;
  logic          pwm_en;
  logic [CW-1:0] count_val;
  logic [CW-1:0] period;
  logic [7:0]    functions;
  logic [CW-1:0] compare1;
  logic [CW-1:0] compare2;
  logic          period_wrap;
  logic          update_pending;
  logic          update_done;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwm_timer_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .count_reset    (count_reset),
    .cfg_update     (cfg_update),
    .cfg_prescale   (cfg_prescale),
    .cfg_period     (cfg_period),
    .cfg_functions  (cfg_functions),
    .cfg_compare1   (cfg_compare1),
    .cfg_compare2   (cfg_compare2),
    .pwm_en         (pwm_en),
    .count_val      (count_val),
    .period         (period),
    .functions      (functions),
    .compare1       (compare1),
    .compare2       (compare2),
    .period_wrap    (period_wrap),
    .update_pending (update_pending),
    .update_done    (update_done)
  );

  typedef struct {
    int presc;
    int per;
    int fn;
    int c1;
    int c2;
  } cfg_t;

  cfg_t m_sh;
  cfg_t m_act;
  bit   m_run, m_pend, m_pwm, m_wrap, m_done;
  int   m_div, m_cnt;

  logic [75:0] got;
  logic [75:0] want;

  assign got = {pwm_en, count_val, period, functions, compare1,
                compare2, period_wrap, update_pending, update_done};

  always_comb begin
    want = {m_pwm, CW'(m_cnt), CW'(m_act.per), 8'(m_act.fn),
            CW'(m_act.c1), CW'(m_act.c2), m_wrap, m_pend, m_done};
  end

  task automatic m_reset();
    m_sh   = '{0, 0, 0, 0, 0};
    m_act  = '{0, 0, 0, 0, 0};
    m_run  = 0;
    m_pend = 0;
    m_pwm  = 0;
    m_wrap = 0;
    m_done = 0;
    m_div  = 0;
    m_cnt  = 0;
  endtask

  // one clock: evaluate the rules on the current inputs, then advance
  task automatic step();
    bit   tick, wrap, apply;
    cfg_t cur;
    cur = '{int'(cfg_prescale), int'(cfg_period), int'(cfg_functions),
            int'(cfg_compare1), int'(cfg_compare2)};
    tick  = m_run && !count_reset && (m_div >= m_act.presc);
    wrap  = tick && (m_cnt >= m_act.per);
    apply = m_pend && !cfg_update && (!m_run || wrap || count_reset);
    @(posedge clk);
    if (count_reset) begin
      m_cnt = 0;
      m_div = 0;
    end else if (tick) begin
      m_cnt = wrap ? 0 : m_cnt + 1;
      m_div = 0;
    end else if (m_run) begin
      m_div++;
    end
    if (apply) m_act = m_sh;
    if (cfg_update) m_sh = cur;
    m_pend = cfg_update || (m_pend && !apply);
    m_run  = en;
    m_pwm  = en;
    m_wrap = wrap;
    m_done = apply;
    #1;
  endtask

  task automatic cfg_write(int ps, int pr, int fn, int c1, int c2);
    cfg_prescale  = PW'(ps);
    cfg_period    = CW'(pr);
    cfg_functions = 8'(fn);
    cfg_compare1  = CW'(c1);
    cfg_compare2  = CW'(c2);
    cfg_update    = 1'b1;
    step();
    cfg_update    = 1'b0;
  endtask

  task automatic test_reset();
    m_reset();
    rst_n = 1'b0;
    #12;
    n_chk++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0", got);
    end
    rst_n = 1'b1;
    step();
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_idle got=%h want=%h", got, want);
    end
  endtask

  task automatic test_count_basic();
    cfg_write(0, 4, 1, 1, 3);
    step();
    n_chk++;
    if (period !== CW'(4) || update_done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_cfg_apply got=%0d/%b want=4/1",
               period, update_done);
    end
    en = 1'b1;
    step();
    n_chk++;
    if (pwm_en !== 1'b1 || count_val !== '0) begin
      n_fail++;
      $display("FAIL basic_pwm_en got=%b/%0d want=1/0", pwm_en, count_val);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      n_chk++;
      if (count_val !== CW'(i % 5) || period_wrap !== 1'(i % 5 == 0)) begin
        n_fail++;
        $display("FAIL basic_seq i=%0d got=%0d/%b want=%0d/%b",
                 i, count_val, period_wrap, i % 5, i % 5 == 0);
      end
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL basic_model got=%h want=%h", got, want);
      end
    end
  endtask

  task automatic test_prescale();
    int last;
    en = 1'b0;
    step();
    count_reset = 1'b1;
    step();
    count_reset = 1'b0;
    cfg_write(2, 2, 0, 1, 2);
    step();
    en = 1'b1;
    last = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL presc_model i=%0d got=%h want=%h", i, got, want);
      end
      if (period_wrap === 1'b1) begin
        if (last >= 0) begin
          n_chk++;
          if (i - last != 9) begin
            n_fail++;
            $display("FAIL presc_wrap_gap got=%0d want=9", i - last);
          end
        end
        last = i;
      end
    end
    n_chk++;
    if (last < 0) begin
      n_fail++;
      $display("FAIL presc_no_wrap got=none want=wrap");
    end
  endtask

  task automatic test_deferred_update();
    int guard;
    en = 1'b0;
    step();
    count_reset = 1'b1;
    step();
    count_reset = 1'b0;
    cfg_write(0, 9, 0, 2, 4);
    step();
    en = 1'b1;
    guard = 0;
    while (count_val !== CW'(5) && guard < 50) begin
      step();
      guard++;
    end
    n_chk++;
    if (count_val !== CW'(5)) begin
      n_fail++;
      $display("FAIL defer_reach5 got=%0d want=5", count_val);
    end
    cfg_period = CW'(3);
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    n_chk++;
    if (update_pending !== 1'b1 || period !== CW'(9)) begin
      n_fail++;
      $display("FAIL defer_pending got=%b/%0d want=1/9",
               update_pending, period);
    end
    guard = 0;
    while (update_done !== 1'b1 && guard < 20) begin
      n_chk++;
      if (period !== CW'(9)) begin
        n_fail++;
        $display("FAIL defer_hold got=%0d want=9", period);
      end
      step();
      guard++;
    end
    n_chk++;
    if (update_done !== 1'b1 || count_val !== '0 || period !== CW'(3)
        || update_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL defer_apply got=%b/%0d/%0d want=1/0/3",
               update_done, count_val, period);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_chk++;
      if (count_val !== CW'(i % 4)) begin
        n_fail++;
        $display("FAIL defer_next got=%0d want=%0d", count_val, i % 4);
      end
    end
  endtask

  task automatic test_update_on_wrap();
    int guard;
    guard = 0;
    while (count_val !== CW'(3) && guard < 20) begin
      step();
      guard++;
    end
    cfg_period = CW'(5);
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    n_chk++;
    if (period_wrap !== 1'b1 || update_done !== 1'b0
        || update_pending !== 1'b1 || period !== CW'(3)) begin
      n_fail++;
      $display("FAIL wrapcoin_hold got=%b%b%b/%0d want=101/3",
               period_wrap, update_done, update_pending, period);
    end
    guard = 0;
    while (update_done !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    n_chk++;
    if (guard != 4 || count_val !== '0 || period !== CW'(5)) begin
      n_fail++;
      $display("FAIL wrapcoin_apply got=%0d/%0d/%0d want=4/0/5",
               guard, count_val, period);
    end
  endtask

  task automatic test_idle_update();
    logic [CW-1:0] frozen;
    en = 1'b0;
    step();
    frozen = count_val;
    cfg_compare1 = CW'(7);
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    n_chk++;
    if (update_pending !== 1'b1 || compare1 !== CW'(2)) begin
      n_fail++;
      $display("FAIL idle_capture got=%b/%0d want=1/2",
               update_pending, compare1);
    end
    step();
    n_chk++;
    if (compare1 !== CW'(7) || update_done !== 1'b1
        || update_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_apply got=%0d/%b/%b want=7/1/0",
               compare1, update_done, update_pending);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if (count_val !== frozen || period_wrap !== 1'b0 || pwm_en !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_frozen got=%0d/%b want=%0d/0",
                 count_val, period_wrap, frozen);
      end
    end
  endtask

  task automatic test_count_reset();
    int guard;
    count_reset = 1'b1;
    step();
    count_reset = 1'b0;
    cfg_write(0, 9, 0, 7, 4);
    step();
    en = 1'b1;
    guard = 0;
    while (count_val !== CW'(4) && guard < 30) begin
      step();
      guard++;
    end
    cfg_compare2 = CW'(11);
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    step();
    n_chk++;
    if (count_val !== CW'(6) || update_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL creset_setup got=%0d/%b want=6/1",
               count_val, update_pending);
    end
    count_reset = 1'b1;
    step();
    count_reset = 1'b0;
    n_chk++;
    if (count_val !== '0 || update_done !== 1'b1 || period_wrap !== 1'b0
        || update_pending !== 1'b0 || compare2 !== CW'(11)) begin
      n_fail++;
      $display("FAIL creset_apply got=%0d/%b/%b/%0d want=0/1/0/11",
               count_val, update_done, period_wrap, compare2);
    end
    step();
    step();
    cfg_compare2 = CW'(12);
    count_reset = 1'b1;
    cfg_update = 1'b1;
    step();
    count_reset = 1'b0;
    cfg_update = 1'b0;
    n_chk++;
    if (count_val !== '0 || update_done !== 1'b0 || update_pending !== 1'b1
        || compare2 !== CW'(11)) begin
      n_fail++;
      $display("FAIL creset_cfg got=%0d/%b/%b/%0d want=0/0/1/11",
               count_val, update_done, update_pending, compare2);
    end
  endtask

  task automatic test_async_reset();
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL async_reset got=%h want=0", got);
    end
    m_reset();
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL async_hold got=%h want=%h", got, want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      en          = ($urandom_range(0, 19) != 0);
      count_reset = ($urandom_range(0, 39) == 0);
      cfg_update  = ($urandom_range(0, 11) == 0);
      if (cfg_update) begin
        cfg_prescale  = PW'($urandom_range(0, 3));
        cfg_period    = CW'($urandom_range(0, 7));
        cfg_functions = 8'($urandom);
        cfg_compare1  = CW'($urandom);
        cfg_compare2  = CW'($urandom);
      end
      step();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, got, want);
      end
    end
    en          = 1'b0;
    count_reset = 1'b0;
    cfg_update  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count_basic();
    test_prescale();
    test_deferred_update();
    test_update_on_wrap();
    test_idle_update();
    test_count_reset();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
